// File: rtl/attn_value_matmul.sv
// Attention context stage: Out[i][n][e] = sum_k A[i][n][k]*V[k][n][e], one MAC per cycle.
// Optional build macro ATTN_AV_ROUND_EN selects round-half-up before the fixed-point shift.
module attn_value_matmul #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
    input  logic [DATA_WIDTH*L*N*E-1:0]  V_in,
    output logic [DATA_WIDTH*L*N*E-1:0]  Out,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid
);

    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = (E > 1) ? $clog2(E) : 1;
    localparam int PW = 2*DATA_WIDTH + 1;
    localparam int AW = PW + LW;

    localparam logic [LW-1:0] K_MAX = LW'(L-1);
    localparam logic [LW-1:0] I_MAX = LW'(L-1);
    localparam logic [NW-1:0] N_MAX = NW'(N-1);
    localparam logic [EW-1:0] E_MAX = EW'(E-1);

    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef ATTN_AV_ROUND_EN
    localparam logic signed [AW-1:0] RND = AW'(64'sd1 <<< (FRAC_BITS-1));
`else
    localparam logic signed [AW-1:0] RND = '0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUTPUT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH*L*N*L-1:0] a_q;
    logic [DATA_WIDTH*L*N*E-1:0] v_q;
    logic [DATA_WIDTH*L*N*E-1:0] res_q;

    logic [LW-1:0] ci, ck;
    logic [NW-1:0] cn;
    logic [EW-1:0] ce;
    logic signed [AW-1:0] acc;

    logic                         last_k, last_mac;
    int                           a_off, v_off, r_off;
    logic [DATA_WIDTH-1:0]        a_e, v_e;
    logic signed [DATA_WIDTH:0]   a_s;
    logic signed [DATA_WIDTH-1:0] v_s;
    logic signed [PW-1:0]         prod;
    logic signed [AW-1:0]         sum, sum_r, shr;
    logic [DATA_WIDTH-1:0]        res_e;

    assign last_k   = (ck == K_MAX);
    assign last_mac = last_k && (ce == E_MAX) && (cn == N_MAX) && (ci == I_MAX);

    // MAC datapath: A is unsigned, so it gets a zero sign bit before the signed multiply
    always_comb begin
        a_off = ((int'(ci)*N*L) + (int'(cn)*L) + int'(ck)) * DATA_WIDTH;
        v_off = ((int'(ck)*N*E) + (int'(cn)*E) + int'(ce)) * DATA_WIDTH;
        r_off = ((int'(ci)*N*E) + (int'(cn)*E) + int'(ce)) * DATA_WIDTH;
        a_e   = a_q[a_off +: DATA_WIDTH];
        v_e   = v_q[v_off +: DATA_WIDTH];
        a_s   = signed'({1'b0, a_e});
        v_s   = signed'(v_e);
        prod  = PW'(a_s) * PW'(v_s);
        sum   = acc + AW'(prod);
        sum_r = sum + RND;
        shr   = sum_r >>> FRAC_BITS;
        if (shr > SAT_MAX)
            res_e = SAT_MAX[DATA_WIDTH-1:0];
        else if (shr < SAT_MIN)
            res_e = SAT_MIN[DATA_WIDTH-1:0];
        else
            res_e = shr[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_MAC;
            S_MAC:    if (last_mac) state_nxt = S_OUTPUT;
            S_OUTPUT: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            v_q       <= '0;
            res_q     <= '0;
            Out       <= '0;
            ci        <= '0;
            cn        <= '0;
            ce        <= '0;
            ck        <= '0;
            acc       <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    ci        <= '0;
                    cn        <= '0;
                    ce        <= '0;
                    ck        <= '0;
                    acc       <= '0;
                    out_valid <= 1'b0;
                end
                S_LOAD: begin
                    a_q <= A_in;
                    v_q <= V_in;
                end
                S_MAC: begin
                    if (last_k) begin
                        res_q[r_off +: DATA_WIDTH] <= res_e;
                        acc <= '0;
                        ck  <= '0;
                        if (ce == E_MAX) begin
                            ce <= '0;
                            if (cn == N_MAX) begin
                                cn <= '0;
                                ci <= (ci == I_MAX) ? '0 : ci + 1'b1;
                            end else begin
                                cn <= cn + 1'b1;
                            end
                        end else begin
                            ce <= ce + 1'b1;
                        end
                    end else begin
                        acc <= sum;
                        ck  <= ck + 1'b1;
                    end
                end
                S_OUTPUT: Out <= res_q;
                S_DONE: begin
                    done      <= 1'b1;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_value_matmul.sv
// Directed bench for attn_value_matmul: identity, uniform, saturation, rounding, control, reset.
module tb_attn_value_matmul;

    localparam int DW = 16;
    localparam int L  = 8;
    localparam int N  = 1;
    localparam int E  = 8;
    localparam int AWD = DW*L*N*L;
    localparam int OW  = DW*L*N*E;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [AWD-1:0] A_in;
    logic [OW-1:0]  V_in;
    logic [OW-1:0]  Out;
    logic           busy, done, out_valid;

    int passes = 0;
    int total  = 0;
    logic [OW-1:0] last_exp = '0;
    logic [OW-1:0] exp_id, exp_v;

    attn_value_matmul #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E), .FRAC_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A_in(A_in), .V_in(V_in),
        .Out(Out), .busy(busy), .done(done), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_identity_a();
        A_in = '0;
        for (int i = 0; i < L; i++)
            for (int n = 0; n < N; n++)
                A_in[((i*N*L) + (n*L) + i)*DW +: DW] = 16'h0100;
    endtask

    // One job from an idle machine: done must rise after edge 515 for exactly one cycle
    task automatic run_job(input string tag, input bit glitch, input logic [OW-1:0] exp);
        int done_edge, dcnt, busy_bad;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_ovfall"}, OW'(out_valid), OW'(0));
        chk({tag, "_hold"}, Out, last_exp);
        chk({tag, "_busy0"}, OW'(busy), OW'(1));
        done_edge = -1; dcnt = 0; busy_bad = 0;
        for (int e = 1; e <= 530; e++) begin
            @(posedge clk); #1;
            if (e == 1 && glitch) begin
                A_in = {AWD/32{$urandom}};
                V_in = {OW/32{$urandom}};
            end
            if (done) begin
                dcnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (busy !== (e <= 514)) busy_bad++;
        end
        chk({tag, "_done_edge"}, OW'(done_edge), OW'(515));
        chk({tag, "_done_width"}, OW'(dcnt), OW'(1));
        chk({tag, "_busy_window"}, OW'(busy_bad), OW'(0));
        chk({tag, "_out"}, Out, exp);
        chk({tag, "_ovalid"}, OW'(out_valid), OW'(1));
        last_exp = exp;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; A_in = '0; V_in = '0;
        #23;
        chk("rst_out", Out, '0);
        chk("rst_done", OW'(done), OW'(0));
        chk("rst_ovalid", OW'(out_valid), OW'(0));
        chk("rst_busy", OW'(busy), OW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        set_identity_a();
        for (int j = 0; j < L*N*E; j++) V_in[j*DW +: DW] = 16'($urandom);
        exp_id = V_in;
        run_job("ident", 1'b0, exp_id);

        A_in = {L*N*L{16'h0020}};
        V_in = {L*N*E{16'h0100}};
        run_job("unif_pos", 1'b0, {L*N*E{16'h0100}});
        V_in = {L*N*E{16'hFF00}};
        run_job("unif_neg", 1'b0, {L*N*E{16'hFF00}});

        A_in = {L*N*L{16'h0100}};
        V_in = {L*N*E{16'h7000}};
        run_job("sat_hi", 1'b0, {L*N*E{16'h7FFF}});
        V_in = {L*N*E{16'h9000}};
        run_job("sat_lo", 1'b0, {L*N*E{16'h8000}});

        A_in = '0;
        A_in[DW-1:0] = 16'h0001;
        V_in = {L*N*E{16'hFF80}};
        exp_v = '0;
`ifdef ATTN_AV_ROUND_EN
        exp_v[E*DW-1:0] = {E{16'h0000}};
`else
        exp_v[E*DW-1:0] = {E{16'hFFFF}};
`endif
        run_job("rnd_neg", 1'b0, exp_v);
        V_in = {L*N*E{16'h0080}};
        exp_v = '0;
`ifdef ATTN_AV_ROUND_EN
        exp_v[E*DW-1:0] = {E{16'h0001}};
`else
        exp_v[E*DW-1:0] = {E{16'h0000}};
`endif
        run_job("rnd_pos", 1'b0, exp_v);

        set_identity_a();
        for (int j = 0; j < L*N*E; j++) V_in[j*DW +: DW] = 16'($urandom);
        exp_id = V_in;
        run_job("glitch", 1'b1, exp_id);

        // start held high: accepted at edges 0 and 516, done at 515 and 1031
        begin
            int d1, d2, dc, ovb;
            set_identity_a();
            V_in = exp_id;
            d1 = -1; d2 = -1; dc = 0; ovb = 1;
            @(negedge clk);
            start = 1'b1;
            for (int e = 0; e <= 1100; e++) begin
                @(posedge clk); #1;
                if (done) begin
                    dc++;
                    if (d1 < 0) d1 = e;
                    else if (d2 < 0) d2 = e;
                end
                if (e == 516) ovb = int'(out_valid);
            end
            start = 1'b0;
            chk("cont_d1", OW'(d1), OW'(515));
            chk("cont_d2", OW'(d2), OW'(1031));
            chk("cont_cnt", OW'(dc), OW'(2));
            chk("cont_ovfall", OW'(ovb), OW'(0));
            for (int j = 0; j < 600 && busy; j++) @(posedge clk);
            #1;
            chk("cont_idle", OW'(busy), OW'(0));
            chk("cont_out", Out, exp_id);
            last_exp = exp_id;
        end

        // async reset in the middle of S_MAC
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 200; e++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_out", Out, '0);
        chk("mrst_done", OW'(done), OW'(0));
        chk("mrst_ovalid", OW'(out_valid), OW'(0));
        chk("mrst_busy", OW'(busy), OW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
        run_job("post_rst", 1'b0, exp_id);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/attn_value_matmul.md
Name: attn_value_matmul

Overview:
- Consumes the row-normalised attention weights produced by the softmax stage and computes the per-head context output, Out[i][n][e] = sum over k of A[i][n][k]*V[k][n][e].
- Sits downstream of softmax in the attention datapath and uses the same flat packed-bus start/done handshake.
- Uses one sequential MAC per cycle, driven by an FSM and nested counters.

Parameters:
- DATA_WIDTH, 16, element width; V and Out are signed fixed-point, A is unsigned fixed-point.
- L, 8, sequence length (rows of A, rows of V).
- N, 1, number of attention heads.
- E, 8, per-head value dimension.
- FRAC_BITS, 8, fractional bits shared by A, V and Out.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a job; sampled only in S_IDLE.
- A_in  input  DATA_WIDTH*L*N*L  weights; element (i,n,k) at bit offset ((i*N*L)+(n*L)+k)*DATA_WIDTH.
- V_in  input  DATA_WIDTH*L*N*E  values; element (k,n,e) at offset ((k*N*E)+(n*E)+e)*DATA_WIDTH.
- Out  output  DATA_WIDTH*L*N*E  result; element (i,n,e) at offset ((i*N*E)+(n*E)+e)*DATA_WIDTH.
- busy  output  1  high in every state except S_IDLE.
- done  output  1  one-cycle completion pulse.
- out_valid  output  1  Out holds a completed result.

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: FSM=S_IDLE; Out=0; done=0; out_valid=0; busy=0; all counters and the accumulator 0. Reset mid-job aborts the job immediately; no done pulse is produced.
- S_IDLE:
  - done<=0.
  - If start: clear counters and accumulator, set out_valid<=0, go to S_LOAD.
  - start in any other state is ignored.
- S_LOAD (1 cycle):
  - Latch A_in and V_in into internal arrays; go to S_MAC.
  - Input changes after this edge have no effect on the job.
- S_MAC (M = L*N*E*L cycles):
  - Loop order: i outermost, then n, then e, then k innermost.
  - Each cycle: p = A[i][n][k] (zero-extended) * V[k][n][e] (signed). p is signed, 2*DATA_WIDTH+1 bits.
  - Accumulator is signed, 2*DATA_WIDTH+1+clog2(L) bits; never overflows.
  - When k<L-1: acc <= acc + p.
  - When k==L-1:
    - s = acc + p, computed combinationally.
    - r = s >>> FRAC_BITS (arithmetic shift; truncation toward -inf).
    - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and write it to result[i][n][e].
    - acc <= 0.
  - After the final MAC (i=L-1, n=N-1, e=E-1, k=L-1), go to S_OUTPUT.
- S_OUTPUT (1 cycle): pack the result array into Out; go to S_DONE.
- S_DONE (1 cycle): done<=1, out_valid<=1; go to S_IDLE. done clears on the next edge.
- Latency:
  - Let the start-sampling edge be edge 0. done is registered high after edge M+3 and low after edge M+4.
  - Defaults: M=512; done high after edge 515.
- Output holding:
  - Out and out_valid hold until the next accepted start. out_valid falls on that start edge; Out keeps its old value until the next S_OUTPUT.
- Back-to-back: start high during the S_DONE cycle is ignored. Earliest re-accept is the first S_IDLE cycle.
- Width rule: clog2 terms use max(1, clog2(x)) so that N=1 builds.

Optional Feature:
- Macro: ATTN_AV_ROUND_EN.
- Defined: round-half-up is applied. When k==L-1, s is replaced by s + 2^(FRAC_BITS-1) before the shift; saturation follows as before.
- Undefined: plain truncating arithmetic shift, exactly as described in Behaviour.
- Latency and interface are identical in both builds.

Test Plan:
- Identity: A[i][0][k]=0x0100 when i==k, else 0; V random -> Out == V bit-exact; done high after edge 515 for exactly one cycle; busy high edges 1..514.
- Uniform: all A=0x0020 (1/8), all V=0x0100 -> every Out element = 0x0100. Then all V=0xFF00 -> every Out element = 0xFF00.
- Saturation: all A=0x0100 with all V=0x7000 -> every Out = 0x7FFF. With all V=0x9000 -> every Out = 0x8000.
- Rounding: A[0][0][0]=0x0001, others 0; V[0][0][e]=0xFF80 -> Out[0][0][e]=0xFFFF without ATTN_AV_ROUND_EN, 0x0000 with it. With V=0x0080 -> 0x0000 truncated, 0x0001 rounded.
- Control:
  - start held high continuously -> exactly one job per 516-cycle period; done pulses never overlap.
  - A_in/V_in changed after edge 1 -> result unaffected.
- Reset mid-S_MAC (edge 200):
  - Expected: Out=0, done=0, out_valid=0, busy=0 immediately.
  - Subsequent start: completes normally with correct Out.
